// File: rtl/ss_conv_if.sv
// Host/sequencer <-> conversion controller <-> ramp/edge-sampler signal bundle.
interface ss_conv_if #(
  parameter int CNT_W = 10
) ();
  logic             start;
  logic             abort;
  logic             cmp_edge;
  logic             ramp_rst;
  logic             ramp_en;
  logic             sampler_rst;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             overflow;
  logic             result_valid;
  logic             result_ready;

  // Host / test sequencer side: requests conversions and consumes results.
  modport master (
    output start, abort, cmp_edge, result_ready,
    input  ramp_rst, ramp_en, sampler_rst, busy, result, overflow, result_valid
  );

  // Controller side.
  modport slave (
    input  start, abort, cmp_edge, result_ready,
    output ramp_rst, ramp_en, sampler_rst, busy, result, overflow, result_valid
  );
endinterface

// File: rtl/ss_conv_ctrl.sv
// Single-slope ADC conversion sequencer: discharge/settle, ramp with cycle
// counter, latch count on first comparator edge, hand result off via
// valid/ready.
module ss_conv_ctrl #(
  parameter int CNT_W         = 10,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  ss_conv_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RAMP   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Last settle-counter value before the ramp is released.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0]       state;
  logic [7:0]       settle_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] result_q;
  logic             overflow_q;
  logic             valid_q;

  // Counter has reached full scale; it must not advance past this value.
  function automatic logic is_saturated(input logic [CNT_W-1:0] v);
    return v == {CNT_W{1'b1}};
  endfunction

  // Sequencer state, counters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      cnt        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state      <= SETTLE;
            settle_cnt <= 8'd0;
          end
        end

        SETTLE: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= RAMP;
            cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        RAMP: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.cmp_edge) begin
            // An edge in the saturation cycle still counts as a real trip.
            result_q   <= cnt;
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            state      <= HOLD;
          end else if (is_saturated(cnt)) begin
            result_q   <= cnt;
            overflow_q <= 1'b1;
            valid_q    <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (bus.abort) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (bus.result_ready) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              state      <= SETTLE;
              settle_cnt <= 8'd0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Analog control and status are pure state decode.
  assign bus.ramp_en      = (state == RAMP);
  assign bus.ramp_rst     = (state != RAMP);
  assign bus.sampler_rst  = (state != RAMP);
  assign bus.busy         = (state == SETTLE) || (state == RAMP);
  assign bus.result       = result_q;
  assign bus.overflow     = overflow_q;
  assign bus.result_valid = valid_q;

endmodule
